losuj_roll: RTL and testbench



---
 rtl/losuj_pkg.sv | 14 +
 rtl/key_debounce.sv | 38 +++
 rtl/losuj_roll.sv | 89 ++++++++
 tb/tb_losuj_roll.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/losuj_pkg.sv
// losuj_pkg: shared state type, constants and helpers for the LOSUJ digit roller
package losuj_pkg;
    typedef enum logic [1:0] {IDLE, ROLL, DRAW, SHOW} state_t;
    localparam logic [3:0] DIGIT_DASH = 4'd10;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int DRAW_MAX_REJECT = 16;
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction
    // Folds 10..15 onto 4..9 so every nibble maps to a displayable digit
    function automatic logic [3:0] fold_digit(input logic [3:0] n);
        return n < 4'd10 ? n : n - 4'd6;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes an active-low key and debounces it into a level plus edge strobes
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic KEY_N,
    output logic level,
    output logic press_evt,
    output logic release_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync_n;
    logic level_q;
    logic pressed;
    logic [CW-1:0] cnt;
    assign pressed = ~sync_n[1];
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_n <= 2'b11;
            level <= 1'b0;
            level_q <= 1'b0;
            cnt <= '0;
        end else begin
            sync_n <= {sync_n[0], KEY_N};
            level_q <= level;
            if (pressed == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= pressed;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
    assign press_evt = level & ~level_q;
    assign release_evt = ~level & level_q;
endmodule

// File: rtl/losuj_roll.sv
// losuj_roll: turns a push-button into a spinning digit that freezes on a uniform random draw
module losuj_roll
    import losuj_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ROLL_DIV = 2_500_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_N,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       rolling,
    output logic       new_result
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int TW = $clog2(ROLL_DIV + 1);
    state_t state;
    logic [15:0] lfsr;
    logic [TW-1:0] tick;
    logic [4:0] rej;
    logic [3:0] nib;
    logic press_evt, release_evt, key_level_unused;
    assign nib = lfsr[3:0];
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .CLOCK_50(CLOCK_50),
        .RESET(RESET),
        .KEY_N(KEY_N),
        .level(key_level_unused),
        .press_evt(press_evt),
        .release_evt(release_evt)
    );
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state <= IDLE;
            lfsr <= SEED;
            tick <= '0;
            rej <= '0;
            digit <= DIGIT_DASH;
            digit_valid <= 1'b0;
            rolling <= 1'b0;
            new_result <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            new_result <= 1'b0;
            case (state)
                IDLE: begin
                    digit <= DIGIT_DASH;
                    if (press_evt) begin
                        state <= ROLL;
                        rolling <= 1'b1;
                        tick <= '0;
                    end
                end
                ROLL: begin
                    if (release_evt) begin
                        state <= DRAW;
                        rolling <= 1'b0;
                        rej <= '0;
                    end else if (tick == TW'(ROLL_DIV - 1)) begin
                        tick <= '0;
                        digit <= fold_digit(nib);
                    end else
                        tick <= tick + TW'(1);
                end
                // Rejection sampling keeps the draw uniform; the fold after the cap bounds latency
                DRAW: begin
                    if (nib < 4'd10 || rej == 5'(DRAW_MAX_REJECT)) begin
                        digit <= fold_digit(nib);
                        new_result <= 1'b1;
                        digit_valid <= 1'b1;
                        state <= SHOW;
                    end else
                        rej <= rej + 5'd1;
                end
                SHOW: begin
                    if (press_evt) begin
                        state <= ROLL;
                        rolling <= 1'b1;
                        digit_valid <= 1'b0;
                        tick <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_losuj_roll.sv
// tb_losuj_roll: table, scripted and randomized checks of losuj_roll against a timing-based reference model
module tb_losuj_roll;
    localparam int DEB = 4;
    localparam int DIV = 3;
    logic CLOCK_50 = 1'b0;
    logic RESET = 1'b1;
    logic KEY_N = 1'b1;
    logic KEY_N0 = 1'b1;
    logic [3:0] digit, digit0;
    logic digit_valid, rolling, new_result, v0, r0, nr0;
    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;
    logic [3:0] cur_digit = 4'd10;
    logic cur_valid = 1'b0;

    typedef struct {
        logic rst;
        logic key_n;
        logic [3:0] d;
        logic v;
        logic r;
        logic nr;
    } vec_t;
    vec_t tbl[16];

    losuj_roll #(.DEBOUNCE_CYCLES(DEB), .ROLL_DIV(DIV), .LFSR_SEED(16'hACE1)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N),
        .digit(digit), .digit_valid(digit_valid), .rolling(rolling), .new_result(new_result)
    );
    losuj_roll #(.DEBOUNCE_CYCLES(DEB), .ROLL_DIV(DIV), .LFSR_SEED(16'h0000)) dut0 (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY_N(KEY_N0),
        .digit(digit0), .digit_valid(v0), .rolling(r0), .new_result(nr0)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference random source: the shift/xor rule, applied once per clock outside reset
    always @(posedge CLOCK_50)
        m_lfsr <= RESET ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] cand(input logic [15:0] l);
        int v;
        v = int'(l % 16);
        return 4'(v < 10 ? v : v - 6);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digit"}, 16'(digit), 16'd10);
        chk({tag, "_flags"}, 16'({digit_valid, rolling, new_result}), 16'd0);
        chk({tag, "_lfsr"}, dut.lfsr, 16'hACE1);
        chk({tag, "_seed0_lfsr"}, dut0.lfsr, 16'h0001);
    endtask

    // One press/hold/release/show cycle; n counts edges after KEY_N goes low.
    // Press is seen at edge 7, release at edge hold+7, spin updates every DIV edges after entry.
    task automatic round(input int hold, input int show_n);
        int d_edge, commit_n, pulses;
        logic [15:0] pv;
        logic [3:0] ed;
        logic ev, er, enr;
        d_edge = hold + 7;
        commit_n = 0;
        pulses = 0;
        ed = cur_digit;
        ev = cur_valid;
        KEY_N = 1'b0;
        for (int n = 1; n <= d_edge + 17 + show_n; n++) begin
            if (n == hold + 1) KEY_N = 1'b1;
            pv = m_lfsr;
            step();
            er = (n >= 7 && n < d_edge);
            enr = 1'b0;
            if (n == 7) ev = 1'b0;
            if (er && n > 7 && (n - 7) % DIV == 0) ed = cand(pv);
            if (n > d_edge && commit_n == 0 && (pv[3:0] < 10 || n == d_edge + 17)) begin
                ed = cand(pv);
                ev = 1'b1;
                enr = 1'b1;
                commit_n = n;
            end
            chk("digit", 16'(digit), 16'(ed));
            chk("digit_valid", 16'(digit_valid), 16'(ev));
            chk("rolling", 16'(rolling), 16'(er));
            chk("new_result", 16'(new_result), 16'(enr));
            pulses += int'(new_result);
            if (commit_n != 0 && n >= commit_n + show_n) break;
        end
        chk("commit_in_window", 16'(commit_n > d_edge && commit_n <= d_edge + 17), 16'd1);
        chk("pulse_count", 16'(pulses), 16'd1);
        cur_digit = ed;
        cur_valid = ev;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            tbl[i] = '{rst: (i < 5), key_n: !(i == 5 || i == 6), d: 4'd10, v: 1'b0, r: 1'b0, nr: 1'b0};
        @(negedge CLOCK_50);
        // Reset hold, then a 2-cycle glitch that must not register as a press
        for (int i = 0; i < 16; i++) begin
            RESET = tbl[i].rst;
            KEY_N = tbl[i].key_n;
            step();
            chk("tbl_digit", 16'(digit), 16'(tbl[i].d));
            chk("tbl_valid", 16'(digit_valid), 16'(tbl[i].v));
            chk("tbl_rolling", 16'(rolling), 16'(tbl[i].r));
            chk("tbl_new_result", 16'(new_result), 16'(tbl[i].nr));
            if (i == 4) begin
                chk("reset_lfsr", dut.lfsr, 16'hACE1);
                chk("seed0_reset_lfsr", dut0.lfsr, 16'h0001);
                chk("seed0_outputs", 16'({digit0, v0, r0, nr0}), 16'({4'd10, 3'b000}));
            end
            if (i == 5) begin
                chk("lfsr_after_reset", dut.lfsr, 16'hE270);
                chk("seed0_lfsr_after_reset", dut0.lfsr, 16'hB400);
            end
        end
        round(20, 100);
        round(int'($urandom_range(10, 40)), 20);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 5)) step();
            round(int'($urandom_range(10, 40)), int'($urandom_range(3, 30)));
        end
        // Reset in the middle of ROLL
        KEY_N = 1'b0;
        repeat (12) step();
        chk("in_roll_before_reset", 16'(rolling), 16'd1);
        RESET = 1'b1;
        KEY_N = 1'b1;
        step();
        chk_reset_outputs("reset_in_roll");
        RESET = 1'b0;
        cur_digit = 4'd10;
        cur_valid = 1'b0;
        round(12, 5);
        // Reset on the first DRAW cycle, before any commit can land
        KEY_N = 1'b0;
        repeat (15) step();
        KEY_N = 1'b1;
        repeat (7) step();
        chk("in_draw_rolling", 16'({rolling, digit_valid, new_result}), 16'd0);
        RESET = 1'b1;
        step();
        chk_reset_outputs("reset_in_draw");
        RESET = 1'b0;
        cur_digit = 4'd10;
        cur_valid = 1'b0;
        round(14, 10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
